// File: rtl/decodificador_secded_if.sv
// decodificador_secded_if
// Groups the decoder's streaming and status signals into one bundle.
//   palabra_in, in_valid / in_ready   : upstream codeword handshake
//   dato_out, sindrome_out,
//   posicion_error, error_simple,
//   error_doble, out_valid / out_ready: downstream result handshake
//   clr_cnt, cnt_simple, cnt_doble     : status counters and their clear
// The master modport is the side that feeds codewords and consumes results.
// The slave modport is the decoder itself.
interface decodificador_secded_if #(
  parameter int CNT_W = 8
) ();
  logic [7:0]       palabra_in;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       dato_out;
  logic [3:0]       sindrome_out;
  logic [3:0]       posicion_error;
  logic             error_simple;
  logic             error_doble;
  logic             out_valid;
  logic             out_ready;
  logic             clr_cnt;
  logic [CNT_W-1:0] cnt_simple;
  logic [CNT_W-1:0] cnt_doble;

  modport master (
    output palabra_in, in_valid, out_ready, clr_cnt,
    input  in_ready, dato_out, sindrome_out, posicion_error,
           error_simple, error_doble, out_valid, cnt_simple, cnt_doble
  );

  modport slave (
    input  palabra_in, in_valid, out_ready, clr_cnt,
    output in_ready, dato_out, sindrome_out, posicion_error,
           error_simple, error_doble, out_valid, cnt_simple, cnt_doble
  );
endinterface

// File: rtl/decodificador_secded.sv
// decodificador_secded
// Receiver side of the Hamming(7,4) + global parity (SECDED) link.
// The received byte is {p0,p1,w0,p2,w1,w2,w3,g0}, holding Hamming positions 1..8.
// Position k sits in bit 8-k.
// Single errors are corrected.
// Double errors are flagged, and the raw data is passed through unchanged.
// The datapath is a two-stage valid/ready pipeline with saturating error counters.
// Ports:
//   clk, rst_n : clock (rising edge) and asynchronous active-low reset
//   bus        : decodificador_secded_if.slave (codeword in, result out, counters)
module decodificador_secded #(
  parameter int CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  decodificador_secded_if.slave bus
);

  logic [2:0]       syn_in;
  logic             ge_in;
  logic [3:0]       dato_in;

  logic             s1_valid;
  logic [3:0]       s1_dato;
  logic [2:0]       s1_syn;
  logic             s1_ge;

  logic             s2_free;
  logic             out_hs;

  logic [3:0]       flip;
  logic [3:0]       dato_corr;
  logic [3:0]       pos_corr;
  logic             simple_corr;
  logic             doble_corr;

  logic             out_valid_q;
  logic [3:0]       dato_q;
  logic [3:0]       sind_q;
  logic [3:0]       pos_q;
  logic             simple_q;
  logic             doble_q;
  logic [CNT_W-1:0] cnt_simple_q;
  logic [CNT_W-1:0] cnt_doble_q;

  // Syndrome bits cover positions {1,3,5,7}, {2,3,6,7} and {4,5,6,7}.
  // Bit index = 8 - position.
  assign syn_in[0] = bus.palabra_in[7] ^ bus.palabra_in[5] ^ bus.palabra_in[3] ^ bus.palabra_in[1];
  assign syn_in[1] = bus.palabra_in[6] ^ bus.palabra_in[5] ^ bus.palabra_in[2] ^ bus.palabra_in[1];
  assign syn_in[2] = bus.palabra_in[4] ^ bus.palabra_in[3] ^ bus.palabra_in[2] ^ bus.palabra_in[1];
  assign ge_in     = ^bus.palabra_in;

  // The parity bits only matter through the syndrome.
  // Stage 1 therefore keeps just the raw data bits w0..w3 (positions 3,5,6,7).
  assign dato_in = {bus.palabra_in[5], bus.palabra_in[3], bus.palabra_in[2], bus.palabra_in[1]};

  // Stage 2 can load when it is empty or its result leaves this cycle.
  assign s2_free      = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid || s2_free;
  assign out_hs       = out_valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_dato  <= '0;
      s1_syn   <= '0;
      s1_ge    <= 1'b0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_dato <= dato_in;
        s1_syn  <= syn_in;
        s1_ge   <= ge_in;
      end
    end
  end

  // Only a data position (3,5,6,7) flips a data bit.
  // A single error on a parity bit, or on g0 (syndrome 0), leaves the data intact.
  always_comb begin
    flip        = 4'b0000;
    simple_corr = s1_ge;
    doble_corr  = !s1_ge && (s1_syn != 3'd0);
    pos_corr    = 4'd0;
    if (s1_ge) begin
      pos_corr = (s1_syn == 3'd0) ? 4'd8 : {1'b0, s1_syn};
      case (s1_syn)
        3'd3:    flip = 4'b1000;
        3'd5:    flip = 4'b0100;
        3'd6:    flip = 4'b0010;
        3'd7:    flip = 4'b0001;
        default: flip = 4'b0000;
      endcase
    end
    dato_corr = s1_dato ^ flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      dato_q      <= '0;
      sind_q      <= '0;
      pos_q       <= '0;
      simple_q    <= 1'b0;
      doble_q     <= 1'b0;
    end else if (s2_free) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        dato_q   <= dato_corr;
        sind_q   <= {s1_ge, s1_syn};
        pos_q    <= pos_corr;
        simple_q <= simple_corr;
        doble_q  <= doble_corr;
      end
    end
  end

  // The counters only count results actually delivered downstream.
  // A clear on the same cycle as an increment wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_simple_q <= '0;
      cnt_doble_q  <= '0;
    end else if (bus.clr_cnt) begin
      cnt_simple_q <= '0;
      cnt_doble_q  <= '0;
    end else if (out_hs) begin
      if (simple_q && (cnt_simple_q != {CNT_W{1'b1}})) cnt_simple_q <= cnt_simple_q + 1'b1;
      if (doble_q && (cnt_doble_q != {CNT_W{1'b1}}))   cnt_doble_q  <= cnt_doble_q + 1'b1;
    end
  end

  assign bus.out_valid      = out_valid_q;
  assign bus.dato_out       = dato_q;
  assign bus.sindrome_out   = sind_q;
  assign bus.posicion_error = pos_q;
  assign bus.error_simple   = simple_q;
  assign bus.error_doble    = doble_q;
  assign bus.cnt_simple     = cnt_simple_q;
  assign bus.cnt_doble      = cnt_doble_q;

endmodule

// File: tb/tb_decodificador_secded.sv
// tb_decodificador_secded
// Self-checking bench for decodificador_secded with CNT_W = 2.
// Codewords come from a position-based Hamming encoder.
// Errors are injected at known positions.
// Expected results follow from the injected positions, not from the received syndrome.
module tb_decodificador_secded;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [3:0] dato;
    logic [3:0] syn;
    logic [3:0] pos;
    logic       es;
    logic       ed;
  } bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  decodificador_secded_if #(.CNT_W(CNT_W)) bus ();

  decodificador_secded #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic bundle_t observed();
    return {bus.dato_out, bus.sindrome_out, bus.posicion_error, bus.error_simple, bus.error_doble};
  endfunction

  function automatic logic getbit(input logic [7:0] w, input int k);
    return w[8-k];
  endfunction

  function automatic logic [7:0] flip_pos(input logic [7:0] w, input int k);
    logic [7:0] r;
    r = w;
    r[8-k] = ~r[8-k];
    return r;
  endfunction

  // Each parity position p covers every data position whose index has p's bit set.
  function automatic logic [7:0] encode(input logic [3:0] d);
    logic b [1:8];
    logic [7:0] w;
    for (int k = 1; k <= 8; k++) b[k] = 1'b0;
    b[3] = d[3];
    b[5] = d[2];
    b[6] = d[1];
    b[7] = d[0];
    for (int p = 1; p <= 4; p = p * 2)
      for (int k = 3; k <= 7; k++)
        if (k != 4 && (k & p) != 0) b[p] = b[p] ^ b[k];
    for (int k = 1; k <= 7; k++) b[8] = b[8] ^ b[k];
    for (int k = 1; k <= 8; k++) w[8-k] = b[k];
    return w;
  endfunction

  task automatic make_case(input int nerr, output logic [7:0] w, output bundle_t e);
    logic [3:0] d;
    int pa;
    int pb;
    d  = 4'($urandom_range(0, 15));
    pa = $urandom_range(1, 8);
    pb = $urandom_range(1, 8);
    while (pb == pa) pb = $urandom_range(1, 8);
    w = encode(d);
    if (nerr == 0) begin
      e = {d, 4'h0, 4'h0, 1'b0, 1'b0};
    end else if (nerr == 1) begin
      w = flip_pos(w, pa);
      e = {d, 1'b1, 3'(pa % 8), 4'(pa), 1'b1, 1'b0};
    end else begin
      w = flip_pos(flip_pos(w, pa), pb);
      e = {getbit(w, 3), getbit(w, 5), getbit(w, 6), getbit(w, 7),
           1'b0, 3'((pa % 8) ^ (pb % 8)), 4'h0, 1'b0, 1'b1};
    end
  endtask

  // Sends one word with out_ready held high.
  // Returns at sample time of the cycle where out_valid appears.
  task automatic push_word(input logic [7:0] w, output int lat, output bit ok);
    int guard;
    @(posedge clk); #1;
    bus.out_ready  = 1'b1;
    bus.clr_cnt    = 1'b0;
    bus.palabra_in = w;
    bus.in_valid   = 1'b1;
    #1;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #2;
      guard++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #2;
      lat++;
    end
    ok = bus.out_valid && (guard < 50);
  endtask

  task automatic test_reset();
    bus.palabra_in = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b1;
    bus.clr_cnt    = 1'b0;
    rst_n = 1'b0;
    #22;
    tests_run++;
    if (bus.out_valid !== 1'b0 || observed() !== bundle_t'(0)) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got v=%b %h, expected v=0 0", bus.out_valid, observed());
    end
    rst_n = 1'b1;
    @(posedge clk); #2;
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
    tests_run++;
    if (bus.cnt_simple !== '0 || bus.cnt_doble !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_counters: got %0d/%0d, expected 0/0", bus.cnt_simple, bus.cnt_doble);
    end
  endtask

  task automatic test_clean();
    int lat;
    bit ok;
    push_word(8'h66, lat, ok);
    tests_run++;
    if (!ok || lat != 2) begin
      tests_failed++;
      $display("[TB] FAIL clean_latency: got %0d (ok=%0b), expected 2", lat, ok);
    end
    tests_run++;
    if (observed() !== bundle_t'({4'b1011, 4'h0, 4'd0, 1'b0, 1'b0})) begin
      tests_failed++;
      $display("[TB] FAIL clean_bundle: got %h, expected %h", observed(), bundle_t'({4'b1011, 4'h0, 4'd0, 2'b00}));
    end
    @(posedge clk); #2;
    tests_run++;
    if (bus.cnt_simple !== 2'd0 || bus.cnt_doble !== 2'd0 || bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL clean_after: got cnt %0d/%0d v=%b, expected 0/0 v=0", bus.cnt_simple, bus.cnt_doble, bus.out_valid);
    end
  endtask

  task automatic test_single();
    int lat;
    bit ok;
    push_word(8'h6E, lat, ok);
    tests_run++;
    if (!ok || observed() !== bundle_t'({4'b1011, 4'hD, 4'd5, 1'b1, 1'b0})) begin
      tests_failed++;
      $display("[TB] FAIL single_bundle: got %h (ok=%0b), expected %h", observed(), ok, bundle_t'({4'b1011, 4'hD, 4'd5, 2'b10}));
    end
    @(posedge clk); #2;
    tests_run++;
    if (bus.cnt_simple !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL single_count: got %0d, expected 1", bus.cnt_simple);
    end
  endtask

  task automatic test_g0();
    int lat;
    bit ok;
    push_word(8'h67, lat, ok);
    tests_run++;
    if (!ok || observed() !== bundle_t'({4'b1011, 4'h8, 4'd8, 1'b1, 1'b0})) begin
      tests_failed++;
      $display("[TB] FAIL g0_bundle: got %h (ok=%0b), expected %h", observed(), ok, bundle_t'({4'b1011, 4'h8, 4'd8, 2'b10}));
    end
    @(posedge clk); #2;
    tests_run++;
    if (bus.cnt_simple !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL g0_count: got %0d, expected 2", bus.cnt_simple);
    end
  endtask

  task automatic test_double();
    int lat;
    bit ok;
    push_word(8'h4E, lat, ok);
    tests_run++;
    if (!ok || observed() !== bundle_t'({4'b0111, 4'h6, 4'd0, 1'b0, 1'b1})) begin
      tests_failed++;
      $display("[TB] FAIL double_bundle: got %h (ok=%0b), expected %h", observed(), ok, bundle_t'({4'b0111, 4'h6, 4'd0, 2'b01}));
    end
    @(posedge clk); #2;
    tests_run++;
    if (bus.cnt_doble !== 2'd1 || bus.cnt_simple !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL double_count: got %0d/%0d, expected 2/1", bus.cnt_simple, bus.cnt_doble);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] words [3];
    bundle_t exp_b [3];
    bundle_t got_q [$];
    int idx;
    int cyc;
    words[0] = 8'h66;
    words[1] = 8'h6E;
    words[2] = 8'h4E;
    exp_b[0] = {4'b1011, 4'h0, 4'd0, 1'b0, 1'b0};
    exp_b[1] = {4'b1011, 4'hD, 4'd5, 1'b1, 1'b0};
    exp_b[2] = {4'b0111, 4'h6, 4'd0, 1'b0, 1'b1};
    idx = 0;
    cyc = 0;
    while (got_q.size() < 3 && cyc < 40) begin
      @(posedge clk); #1;
      bus.in_valid = (idx < 3);
      if (idx < 3) bus.palabra_in = words[idx];
      bus.out_ready = (cyc >= 5);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || observed() !== exp_b[0]) begin
          tests_failed++;
          $display("[TB] FAIL bp_hold_c%0d: got v=%b %h, expected v=1 %h", cyc, bus.out_valid, observed(), exp_b[0]);
        end
      end
      if (cyc == 4) begin
        tests_run++;
        if (idx != 2 || bus.in_ready !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL bp_stall: got accepts=%0d in_ready=%b, expected 2 and 0", idx, bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) got_q.push_back(observed());
      if (bus.in_valid && bus.in_ready) idx++;
      cyc++;
    end
    bus.in_valid = 1'b0;
    tests_run++;
    if (got_q.size() != 3) begin
      tests_failed++;
      $display("[TB] FAIL bp_count: got %0d outputs, expected 3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      tests_run++;
      if (got_q[i] !== exp_b[i]) begin
        tests_failed++;
        $display("[TB] FAIL bp_order_%0d: got %h, expected %h", i, got_q[i], exp_b[i]);
      end
    end
    @(posedge clk); #2;
    tests_run++;
    if (bus.out_valid !== 1'b0 || bus.cnt_simple !== 2'd3 || bus.cnt_doble !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL bp_after: got v=%b cnt %0d/%0d, expected v=0 3/2", bus.out_valid, bus.cnt_simple, bus.cnt_doble);
    end
  endtask

  task automatic test_saturation();
    logic [7:0] w;
    bundle_t e;
    int lat;
    bit ok;
    @(posedge clk); #1;
    bus.clr_cnt = 1'b1;
    @(posedge clk); #1;
    bus.clr_cnt = 1'b0;
    #1;
    tests_run++;
    if (bus.cnt_simple !== 2'd0 || bus.cnt_doble !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL sat_clear: got %0d/%0d, expected 0/0", bus.cnt_simple, bus.cnt_doble);
    end
    for (int i = 0; i < 5; i++) begin
      make_case(1, w, e);
      push_word(w, lat, ok);
      tests_run++;
      if (!ok || observed() !== e) begin
        tests_failed++;
        $display("[TB] FAIL sat_word_%0d: got %h (ok=%0b), expected %h", i, observed(), ok, e);
      end
    end
    @(posedge clk); #2;
    tests_run++;
    if (bus.cnt_simple !== CNT_MAX) begin
      tests_failed++;
      $display("[TB] FAIL sat_value: got %0d, expected %0d", bus.cnt_simple, CNT_MAX);
    end
    make_case(1, w, e);
    push_word(w, lat, ok);
    bus.clr_cnt = 1'b1;
    @(posedge clk); #1;
    bus.clr_cnt = 1'b0;
    #1;
    tests_run++;
    if (bus.cnt_simple !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL sat_clear_wins: got %0d, expected 0", bus.cnt_simple);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 200;
    bundle_t q [$];
    bundle_t pending;
    bundle_t held;
    bundle_t e;
    logic [7:0] w;
    int sent;
    int got;
    int cyc;
    int exp_s;
    int exp_d;
    bit accepted;
    bit prev_stall;
    sent = 0;
    got = 0;
    cyc = 0;
    exp_s = 0;
    exp_d = 0;
    accepted = 1'b0;
    prev_stall = 1'b0;
    held = '0;
    pending = '0;
    while (got < N && cyc < 5000) begin
      @(posedge clk); #1;
      if (accepted) bus.in_valid = 1'b0;
      if (!bus.in_valid && sent < N && $urandom_range(0, 3) != 0) begin
        make_case($urandom_range(0, 2), w, e);
        bus.palabra_in = w;
        bus.in_valid   = 1'b1;
        pending        = e;
      end
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (prev_stall) begin
        tests_run++;
        if (bus.out_valid !== 1'b1 || observed() !== held) begin
          tests_failed++;
          $display("[TB] FAIL b2b_hold: got v=%b %h, expected v=1 %h", bus.out_valid, observed(), held);
        end
      end
      accepted = bus.in_valid && bus.in_ready;
      if (accepted) begin
        q.push_back(pending);
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        tests_run++;
        if (q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL b2b_spurious: got output %h, expected none", observed());
        end else begin
          e = q.pop_front();
          if (observed() !== e) begin
            tests_failed++;
            $display("[TB] FAIL b2b_word_%0d: got %h, expected %h", got, observed(), e);
          end
        end
        if (bus.error_simple) exp_s++;
        if (bus.error_doble) exp_d++;
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      held = observed();
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tests_run++;
    if (got != N) begin
      tests_failed++;
      $display("[TB] FAIL b2b_timeout: got %0d outputs, expected %0d", got, N);
    end
    @(posedge clk); #2;
    tests_run++;
    if (int'(bus.cnt_simple) != ((exp_s > 3) ? 3 : exp_s) || int'(bus.cnt_doble) != ((exp_d > 3) ? 3 : exp_d)) begin
      tests_failed++;
      $display("[TB] FAIL b2b_counters: got %0d/%0d, expected %0d/%0d", bus.cnt_simple, bus.cnt_doble,
               (exp_s > 3) ? 3 : exp_s, (exp_d > 3) ? 3 : exp_d);
    end
  endtask

  task automatic test_async_reset();
    int seen;
    @(posedge clk); #1;
    bus.out_ready  = 1'b0;
    bus.palabra_in = 8'h6E;
    bus.in_valid   = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    tests_run++;
    if (bus.out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL arst_pre: got out_valid=%b, expected 1", bus.out_valid);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus.out_valid !== 1'b0 || observed() !== bundle_t'(0) || bus.cnt_simple !== '0 || bus.cnt_doble !== '0) begin
      tests_failed++;
      $display("[TB] FAIL arst_now: got v=%b %h cnt %0d/%0d, expected v=0 0 0/0", bus.out_valid, observed(), bus.cnt_simple, bus.cnt_doble);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #2;
      if (bus.out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("[TB] FAIL arst_flush: got %0d valid cycles, expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_g0();
    test_double();
    test_backpressure();
    test_saturation();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
